// File: rtl/reflet_subword_access_pkg.sv
// -----------------------------------------------------------------------------
// reflet_subword_access_pkg
// Shared definitions for the Reflet load/store unit: size codes, FSM state
// encoding and the size-code to effective-byte-count mapping used by both the
// top level and the lane merge datapath.
// -----------------------------------------------------------------------------
package reflet_subword_access_pkg;

   // CPU size codes
   localparam logic [1:0] SIZE_FULL = 2'b00;
   localparam logic [1:0] SIZE_32   = 2'b01;
   localparam logic [1:0] SIZE_16   = 2'b10;
   localparam logic [1:0] SIZE_8    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR,
      ST_DONE
   } state_t;

   // Effective access size in bytes. A sub-word code at least as wide as the
   // RAM word collapses to a full-word access.
   function automatic logic [5:0] access_bytes_f(input logic [1:0] size,
                                                 input int         wordsize);
      int full_bytes;
      int req_bytes;
      full_bytes = wordsize / 8;
      case (size)
         SIZE_32: req_bytes = 4;
         SIZE_16: req_bytes = 2;
         SIZE_8:  req_bytes = 1;
         default: req_bytes = full_bytes;
      endcase
      if (req_bytes > full_bytes) begin
         req_bytes = full_bytes;
      end
      return 6'(req_bytes);
   endfunction

endpackage

// File: rtl/reflet_subword_access_if.sv
// -----------------------------------------------------------------------------
// reflet_subword_access_if
// CPU-side request/done bus of the Reflet load/store unit.
//   master : the CPU core (drives request fields, receives result/done/err)
//   slave  : the load/store unit
// Signals:
//   cpu_req, cpu_write, cpu_size, cpu_addr, cpu_wdata  CPU -> unit
//   cpu_rdata, cpu_done, cpu_err, access_bytes         unit -> CPU
// -----------------------------------------------------------------------------
interface reflet_subword_access_if #(
   parameter int wordsize   = 16,
   parameter int addr_width = 16
);
   logic                  cpu_req;
   logic                  cpu_write;
   logic [1:0]            cpu_size;
   logic [addr_width-1:0] cpu_addr;
   logic [wordsize-1:0]   cpu_wdata;
   logic [wordsize-1:0]   cpu_rdata;
   logic                  cpu_done;
   logic                  cpu_err;
   logic [5:0]            access_bytes;

   modport master (
      output cpu_req, cpu_write, cpu_size, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_err, access_bytes
   );

   modport slave (
      input  cpu_req, cpu_write, cpu_size, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_err, access_bytes
   );
endinterface

// File: rtl/reflet_lane_merge.sv
// -----------------------------------------------------------------------------
// reflet_lane_merge
// Combinational lane datapath of the load/store unit (little-endian lanes).
// Ports:
//   word      : full RAM word being read
//   lane_data : right-aligned store data
//   offset    : byte offset of the lane inside the word
//   size      : CPU size code (reduced to the effective byte count here)
//   lane_out  : addressed lane of word, right-aligned and zero-extended
//   merged    : word with the addressed lane replaced by lane_data
// -----------------------------------------------------------------------------
module reflet_lane_merge
   import reflet_subword_access_pkg::*;
#(
   parameter int wordsize = 16
) (
   input  logic [wordsize-1:0] word,
   input  logic [wordsize-1:0] lane_data,
   input  logic [5:0]          offset,
   input  logic [1:0]          size,
   output logic [wordsize-1:0] lane_out,
   output logic [wordsize-1:0] merged
);

   localparam int NBYTES = wordsize / 8;

   logic [5:0]          nbytes;
   logic [8:0]          shamt;
   logic [wordsize-1:0] lane_mask;
   logic [wordsize-1:0] shifted_mask;
   logic [wordsize-1:0] shifted_data;

   always_comb begin
      nbytes    = access_bytes_f(size, wordsize);
      shamt     = {offset, 3'b000};
      // Right-aligned mask covering the low nbytes bytes; built per byte so
      // a full 128-bit access never needs an oversized shift.
      lane_mask = '0;
      for (int b = 0; b < NBYTES; b++) begin
         lane_mask[b*8 +: 8] = (b < int'(nbytes)) ? 8'hFF : 8'h00;
      end
      shifted_mask = lane_mask << shamt;
      shifted_data = (lane_data & lane_mask) << shamt;
      lane_out     = (word >> shamt) & lane_mask;
      merged       = (word & ~shifted_mask) | shifted_data;
   end

endmodule

// File: rtl/reflet_subword_access.sv
// -----------------------------------------------------------------------------
// reflet_subword_access
// Load/store unit between the Reflet CPU core and a single-port synchronous
// RAM. Byte-addressed requests of full/32/16/8-bit size are split into a RAM
// word address and lane offset; sub-word loads are extracted and
// zero-extended, sub-word stores run a read-modify-write so neighbouring lanes
// survive. Misaligned requests complete at once with cpu_err set.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   cpu        : CPU request/done bus (slave side)
//   ram_addr   : registered RAM word address
//   ram_wdata  : registered RAM write data
//   ram_we     : registered RAM write enable (one cycle per store)
//   ram_rdata  : RAM read data, valid one cycle after ram_addr
// -----------------------------------------------------------------------------
module reflet_subword_access
   import reflet_subword_access_pkg::*;
#(
   parameter int wordsize   = 16,
   parameter int addr_width = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   reflet_subword_access_if.slave    cpu,
   output logic [addr_width-1:0]     ram_addr,
   output logic [wordsize-1:0]       ram_wdata,
   output logic                      ram_we,
   input  logic [wordsize-1:0]       ram_rdata
);

   localparam int                    LANE_BITS  = $clog2(wordsize / 8);
   localparam logic [5:0]            FULL_BYTES = 6'(wordsize / 8);
   localparam logic [addr_width-1:0] LANE_MASK  = addr_width'((1 << LANE_BITS) - 1);

   // Request decode (valid while cpu_req is presented in IDLE)
   logic [5:0] req_bytes;
   logic [5:0] req_offset;
   logic       req_misaligned;
   logic       req_full;

   state_t                state_q, state_d;
   logic                  op_write_q, op_write_d;
   logic [1:0]            op_size_q, op_size_d;
   logic [5:0]            op_offset_q, op_offset_d;
   logic [wordsize-1:0]   op_wdata_q, op_wdata_d;
   logic                  err_q, err_d;
   logic [wordsize-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [addr_width-1:0] ram_addr_q, ram_addr_d;
   logic [wordsize-1:0]   ram_wdata_q, ram_wdata_d;
   logic                  ram_we_q, ram_we_d;

   logic [wordsize-1:0]   lane_out;
   logic [wordsize-1:0]   merged;

   assign cpu.access_bytes = access_bytes_f(cpu.cpu_size, wordsize);

   assign req_bytes      = cpu.access_bytes;
   assign req_offset     = 6'(cpu.cpu_addr & LANE_MASK);
   // access_bytes is a power of two, so alignment is a mask test
   assign req_misaligned = |(req_offset & (req_bytes - 6'd1));
   assign req_full       = (req_bytes == FULL_BYTES);

   // Lane datapath works on the latched request so the CPU is free to change
   // its inputs once the request has been accepted.
   reflet_lane_merge #(
      .wordsize (wordsize)
   ) u_lane_merge (
      .word      (ram_rdata),
      .lane_data (op_wdata_q),
      .offset    (op_offset_q),
      .size      (op_size_q),
      .lane_out  (lane_out),
      .merged    (merged)
   );

   // State / datapath register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of every other flop.
      if (!reset) begin
         state_q     <= ST_IDLE;
         op_write_q  <= 1'b0;
         op_size_q   <= SIZE_FULL;
         op_offset_q <= '0;
         op_wdata_q  <= '0;
         err_q       <= 1'b0;
         cpu_rdata_q <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_write_q  <= op_write_d;
         op_size_q   <= op_size_d;
         op_offset_q <= op_offset_d;
         op_wdata_q  <= op_wdata_d;
         err_q       <= err_d;
         cpu_rdata_q <= cpu_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch;
      // a path that leaves one unassigned would infer a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu.cpu_req) begin
               if (req_misaligned) begin
                  state_d = ST_DONE;
               end else if (cpu.cpu_write && req_full) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD_ISSUE;
               end
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT:  state_d = op_write_q ? ST_WR : ST_DONE;
         ST_WR:       state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      op_write_d  = op_write_q;
      op_size_d   = op_size_q;
      op_offset_d = op_offset_q;
      op_wdata_d  = op_wdata_q;
      err_d       = err_q;
      cpu_rdata_d = cpu_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu.cpu_req) begin
               op_write_d  = cpu.cpu_write;
               op_size_d   = cpu.cpu_size;
               op_offset_d = req_offset;
               op_wdata_d  = cpu.cpu_wdata;
               err_d       = req_misaligned;
               if (!req_misaligned) begin
                  ram_addr_d = cpu.cpu_addr >> LANE_BITS;
                  if (cpu.cpu_write && req_full) begin
                     ram_wdata_d = cpu.cpu_wdata;
                     ram_we_d    = 1'b1;
                  end
               end
            end
         end
         ST_RD_WAIT: begin
            if (op_write_q) begin
               ram_wdata_d = merged;
               ram_we_d    = 1'b1;
            end else begin
               cpu_rdata_d = lane_out;
            end
         end
         ST_DONE: err_d = 1'b0;
         default: ;
      endcase
   end

   assign cpu.cpu_done  = (state_q == ST_DONE);
   assign cpu.cpu_err   = (state_q == ST_DONE) && err_q;
   assign cpu.cpu_rdata = cpu_rdata_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign ram_we        = ram_we_q;

endmodule

// File: tb/tb_reflet_subword_access.sv
// -----------------------------------------------------------------------------
// tb_reflet_subword_access
// Directed bench for reflet_subword_access with a 32-bit and a 16-bit instance,
// each attached to a small synchronous RAM model.
// -----------------------------------------------------------------------------
module tb_reflet_subword_access;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   // ---------------- 32-bit instance ----------------
   reflet_subword_access_if #(.wordsize(32), .addr_width(16)) c32 ();
   logic [15:0] ram_addr32;
   logic [31:0] ram_wdata32, ram_rdata32;
   logic        ram_we32;
   logic [31:0] mem32 [0:65535];
   logic        poke32_en = 1'b0;
   logic [15:0] poke32_idx = '0;
   logic [31:0] poke32_val = '0;

   reflet_subword_access #(.wordsize(32), .addr_width(16)) u32 (
      .clk       (clk),
      .reset     (rst_n),
      .cpu       (c32),
      .ram_addr  (ram_addr32),
      .ram_wdata (ram_wdata32),
      .ram_we    (ram_we32),
      .ram_rdata (ram_rdata32)
   );

   always @(posedge clk) begin
      if (ram_we32) mem32[ram_addr32] <= ram_wdata32;
      else if (poke32_en) mem32[poke32_idx] <= poke32_val;
      ram_rdata32 <= mem32[ram_addr32];
   end

   // ---------------- 16-bit instance ----------------
   reflet_subword_access_if #(.wordsize(16), .addr_width(16)) c16 ();
   logic [15:0] ram_addr16;
   logic [15:0] ram_wdata16, ram_rdata16;
   logic        ram_we16;
   logic [15:0] mem16 [0:65535];

   reflet_subword_access #(.wordsize(16), .addr_width(16)) u16 (
      .clk       (clk),
      .reset     (rst_n),
      .cpu       (c16),
      .ram_addr  (ram_addr16),
      .ram_wdata (ram_wdata16),
      .ram_we    (ram_we16),
      .ram_rdata (ram_rdata16)
   );

   always @(posedge clk) begin
      if (ram_we16) mem16[ram_addr16] <= ram_wdata16;
      ram_rdata16 <= mem16[ram_addr16];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One request on the 32-bit unit; latency is counted from the req edge.
   task automatic run32(input logic wr, input logic [1:0] sz, input logic [15:0] addr,
                        input logic [31:0] wd, output int lat, output logic err,
                        output int we_cnt, output int we_cyc,
                        output logic [15:0] we_addr, output logic [31:0] we_data);
      c32.cpu_req = 1'b1; c32.cpu_write = wr; c32.cpu_size = sz;
      c32.cpu_addr = addr; c32.cpu_wdata = wd;
      we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = '0;
      @(posedge clk); #1;
      c32.cpu_req = 1'b0;
      lat = 1;
      while (lat <= 12) begin
         if (ram_we32) begin
            we_cnt++;
            if (we_cyc == 0) begin
               we_cyc = lat; we_addr = ram_addr32; we_data = ram_wdata32;
            end
         end
         if (c32.cpu_done) break;
         @(posedge clk); #1;
         lat++;
      end
      err = c32.cpu_err;
      @(posedge clk); #1;
   endtask

   task automatic run16(input logic wr, input logic [1:0] sz, input logic [15:0] addr,
                        input logic [15:0] wd, output int lat, output logic err,
                        output int we_cnt, output int we_cyc,
                        output logic [15:0] we_addr, output logic [15:0] we_data);
      c16.cpu_req = 1'b1; c16.cpu_write = wr; c16.cpu_size = sz;
      c16.cpu_addr = addr; c16.cpu_wdata = wd;
      we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = '0;
      @(posedge clk); #1;
      c16.cpu_req = 1'b0;
      lat = 1;
      while (lat <= 12) begin
         if (ram_we16) begin
            we_cnt++;
            if (we_cyc == 0) begin
               we_cyc = lat; we_addr = ram_addr16; we_data = ram_wdata16;
            end
         end
         if (c16.cpu_done) break;
         @(posedge clk); #1;
         lat++;
      end
      err = c16.cpu_err;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, we_cnt, we_cyc;
      logic        err;
      logic [15:0] wa;
      logic [31:0] wd32;
      logic [15:0] wd16;
      logic        we_seen;
      int          first_done, second_done, n_done;
      logic [31:0] rd_first, rd_second;

      rst_n = 1'b0;
      c32.cpu_req = 1'b0; c32.cpu_write = 1'b0; c32.cpu_size = 2'b00;
      c32.cpu_addr = '0; c32.cpu_wdata = '0;
      c16.cpu_req = 1'b0; c16.cpu_write = 1'b0; c16.cpu_size = 2'b00;
      c16.cpu_addr = '0; c16.cpu_wdata = '0;

      // Preload RAM[1] = 0xAABBCCDD while held in reset
      @(posedge clk); #1;
      poke32_en = 1'b1; poke32_idx = 16'h0001; poke32_val = 32'hAABBCCDD;
      @(posedge clk); #1;
      poke32_en = 1'b0;

      // Reset state
      check("rst_done32",  64'(c32.cpu_done), 64'(0));
      check("rst_err32",   64'(c32.cpu_err), 64'(0));
      check("rst_rdata32", 64'(c32.cpu_rdata), 64'(0));
      check("rst_we32",    64'(ram_we32), 64'(0));
      check("rst_addr32",  64'(ram_addr32), 64'(0));
      check("rst_wdata32", 64'(ram_wdata32), 64'(0));
      check("rst_done16",  64'(c16.cpu_done), 64'(0));

      // Effective size (combinational)
      c32.cpu_size = 2'b11; c16.cpu_size = 2'b11; #1;
      check("ab32_s11", 64'(c32.access_bytes), 64'(1));
      check("ab16_s11", 64'(c16.access_bytes), 64'(1));
      c32.cpu_size = 2'b10; c16.cpu_size = 2'b10; #1;
      check("ab32_s10", 64'(c32.access_bytes), 64'(2));
      check("ab16_s10", 64'(c16.access_bytes), 64'(2));
      c32.cpu_size = 2'b01; c16.cpu_size = 2'b01; #1;
      check("ab32_s01", 64'(c32.access_bytes), 64'(4));
      check("ab16_s01", 64'(c16.access_bytes), 64'(2));
      c32.cpu_size = 2'b00; c16.cpu_size = 2'b00; #1;
      check("ab32_s00", 64'(c32.access_bytes), 64'(4));
      check("ab16_s00", 64'(c16.access_bytes), 64'(2));

      rst_n = 1'b1;
      @(posedge clk); #1;

      // Byte load, lane 2 of word 1
      run32(1'b0, 2'b11, 16'h0006, 32'h0, lat, err, we_cnt, we_cyc, wa, wd32);
      check("ld8_rdata", 64'(c32.cpu_rdata), 64'(32'h000000BB));
      check("ld8_lat",   64'(lat), 64'(3));
      check("ld8_err",   64'(err), 64'(0));
      check("ld8_nowe",  64'(we_cnt), 64'(0));

      // Halfword store, lane 0; upper wdata bits must be ignored
      run32(1'b1, 2'b10, 16'h0004, 32'hFFFF1234, lat, err, we_cnt, we_cyc, wa, wd32);
      check("st16_lat",    64'(lat), 64'(4));
      check("st16_wecnt",  64'(we_cnt), 64'(1));
      check("st16_wecyc",  64'(we_cyc), 64'(3));
      check("st16_weaddr", 64'(wa), 64'(16'h0001));
      check("st16_wedata", 64'(wd32), 64'(32'hAABB1234));
      check("st16_mem",    64'(mem32[1]), 64'(32'hAABB1234));
      check("st16_rdhold", 64'(c32.cpu_rdata), 64'(32'h000000BB));

      // Byte store into top lane
      run32(1'b1, 2'b11, 16'h0007, 32'h0000005A, lat, err, we_cnt, we_cyc, wa, wd32);
      check("st8_lat", 64'(lat), 64'(4));
      check("st8_mem", 64'(mem32[1]), 64'(32'h5ABB1234));

      // Full-word load
      run32(1'b0, 2'b00, 16'h0004, 32'h0, lat, err, we_cnt, we_cyc, wa, wd32);
      check("ldw_rdata", 64'(c32.cpu_rdata), 64'(32'h5ABB1234));
      check("ldw_lat",   64'(lat), 64'(3));

      // Halfword load from upper half
      run32(1'b0, 2'b10, 16'h0006, 32'h0, lat, err, we_cnt, we_cyc, wa, wd32);
      check("ld16_rdata", 64'(c32.cpu_rdata), 64'(32'h00005ABB));

      // Misaligned halfword load
      run32(1'b0, 2'b10, 16'h0003, 32'h0, lat, err, we_cnt, we_cyc, wa, wd32);
      check("mis_lat",    64'(lat), 64'(1));
      check("mis_err",    64'(err), 64'(1));
      check("mis_nowe",   64'(we_cnt), 64'(0));
      check("mis_rdhold", 64'(c32.cpu_rdata), 64'(32'h00005ABB));
      check("mis_errclr", 64'(c32.cpu_err), 64'(0));

      // Misaligned 32-bit store: no RAM activity
      run32(1'b1, 2'b01, 16'h0006, 32'h11111111, lat, err, we_cnt, we_cyc, wa, wd32);
      check("mis32_err",  64'(err), 64'(1));
      check("mis32_nowe", 64'(we_cnt), 64'(0));
      check("mis32_mem",  64'(mem32[1]), 64'(32'h5ABB1234));

      // Full-word store
      run32(1'b1, 2'b00, 16'h0008, 32'hDEADBEEF, lat, err, we_cnt, we_cyc, wa, wd32);
      check("stw_lat",    64'(lat), 64'(2));
      check("stw_wecyc",  64'(we_cyc), 64'(1));
      check("stw_wecnt",  64'(we_cnt), 64'(1));
      check("stw_weaddr", 64'(wa), 64'(16'h0002));
      check("stw_mem",    64'(mem32[2]), 64'(32'hDEADBEEF));

      // 16-bit unit: size 01 reduces to a full-word store
      c16.cpu_size = 2'b01; #1;
      check("ab16_full", 64'(c16.access_bytes), 64'(2));
      run16(1'b1, 2'b01, 16'h0002, 16'hBEEF, lat, err, we_cnt, we_cyc, wa, wd16);
      check("w16_lat",    64'(lat), 64'(2));
      check("w16_wecyc",  64'(we_cyc), 64'(1));
      check("w16_weaddr", 64'(wa), 64'(16'h0001));
      check("w16_wedata", 64'(wd16), 64'(16'hBEEF));
      check("w16_err",    64'(err), 64'(0));

      run16(1'b0, 2'b11, 16'h0003, 16'h0, lat, err, we_cnt, we_cyc, wa, wd16);
      check("w16_ld8",     64'(c16.cpu_rdata), 64'(16'h00BE));
      check("w16_ld8_lat", 64'(lat), 64'(3));

      run16(1'b1, 2'b11, 16'h0002, 16'hFFC3, lat, err, we_cnt, we_cyc, wa, wd16);
      check("w16_st8_lat", 64'(lat), 64'(4));
      check("w16_st8_mem", 64'(mem16[1]), 64'(16'hBEC3));

      run16(1'b0, 2'b10, 16'h0001, 16'h0, lat, err, we_cnt, we_cyc, wa, wd16);
      check("w16_mis_err", 64'(err), 64'(1));

      // Reset during RD_WAIT of a sub-word store
      we_seen = 1'b0;
      c32.cpu_req = 1'b1; c32.cpu_write = 1'b1; c32.cpu_size = 2'b11;
      c32.cpu_addr = 16'h0004; c32.cpu_wdata = 32'h00000077;
      @(posedge clk); #1;              // RD_ISSUE
      c32.cpu_req = 1'b0;
      we_seen |= ram_we32;
      @(posedge clk); #1;              // RD_WAIT
      we_seen |= ram_we32;
      rst_n = 1'b0;
      @(posedge clk); #1;              // reset taken
      we_seen |= ram_we32;
      check("rmw_rst_done",  64'(c32.cpu_done), 64'(0));
      check("rmw_rst_rdata", 64'(c32.cpu_rdata), 64'(0));
      check("rmw_rst_addr",  64'(ram_addr32), 64'(0));
      check("rmw_rst_wdata", 64'(ram_wdata32), 64'(0));
      rst_n = 1'b1;
      run32(1'b0, 2'b11, 16'h0007, 32'h0, lat, err, we_cnt, we_cyc, wa, wd32);
      we_seen |= (we_cnt != 0);
      check("rmw_rst_nowe",  64'(we_seen), 64'(0));
      check("rmw_rst_mem",   64'(mem32[1]), 64'(32'h5ABB1234));
      check("post_rst_ld",   64'(c32.cpu_rdata), 64'(32'h0000005A));
      check("post_rst_lat",  64'(lat), 64'(3));

      // Back-to-back: req held high; address changed while busy
      first_done = 0; second_done = 0; n_done = 0;
      rd_first = '0; rd_second = '0;
      c32.cpu_req = 1'b1; c32.cpu_write = 1'b0; c32.cpu_size = 2'b11;
      c32.cpu_addr = 16'h0004;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) c32.cpu_addr = 16'h0005;
         if (c32.cpu_done) begin
            n_done++;
            if (first_done == 0) begin
               first_done = cyc; rd_first = c32.cpu_rdata;
            end else if (second_done == 0) begin
               second_done = cyc; rd_second = c32.cpu_rdata;
               c32.cpu_req = 1'b0;
            end
         end
      end
      c32.cpu_req = 1'b0;
      check("b2b_first_cyc",  64'(first_done), 64'(3));
      check("b2b_first_data", 64'(rd_first), 64'(32'h00000034));
      check("b2b_second_cyc", 64'(second_done), 64'(7));
      check("b2b_second_data", 64'(rd_second), 64'(32'h00000012));
      check("b2b_ndone",      64'(n_done), 64'(2));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reflet_subword_access.md
Name: reflet_subword_access

Overview:
- Parametrised load/store unit between the Reflet CPU core and a single-port synchronous RAM.
- Each access carries a size code: full word, 32-bit, 16-bit or 8-bit.
- Sub-word loads are extracted from the addressed lane and zero-extended.
- Sub-word stores run a real read-modify-write, so neighbouring lanes in the RAM word are preserved.
- Adds byte addressing, lane selection, misalignment detection and a request/done handshake.

Parameters:
- wordsize, 16: CPU/RAM word width in bits. Legal values: 8, 16, 32, 64, 128.
- addr_width, 16: byte-address width on the CPU side.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- cpu_req  input  1  access request; sampled only in IDLE
- cpu_write  input  1  1 = store, 0 = load
- cpu_size  input  2  size code: 00 = full word, 01 = 32-bit, 10 = 16-bit, 11 = 8-bit
- cpu_addr  input  addr_width  byte address
- cpu_wdata  input  wordsize  store data; right-aligned for sub-word stores
- cpu_rdata  output  wordsize  load result, zero-extended, right-aligned
- cpu_done  output  1  one-cycle completion pulse
- cpu_err  output  1  misaligned access flag; valid while cpu_done is high
- access_bytes  output  6  effective access size in bytes (combinational from cpu_size)
- ram_addr  output  addr_width  RAM word address (registered)
- ram_wdata  output  wordsize  RAM write data (registered)
- ram_we  output  1  RAM write enable (registered)
- ram_rdata  input  wordsize  RAM read data; valid one cycle after ram_addr is presented

Behaviour:
- Reset: while reset=0 at a clock edge, the FSM goes to IDLE and cpu_rdata, cpu_done, cpu_err, ram_addr, ram_wdata and ram_we all clear to 0. Reset mid-operation aborts the access; ram_we is 0 from the next edge; no done pulse is produced.
- Effective size: a size code whose width is >= wordsize is treated as full word (for example, code 01 with wordsize=16).
  - access_bytes = 4, 2 or 1 for codes 01, 10, 11 when reduced; wordsize/8 otherwise.
- Address split:
  - L = log2(wordsize/8).
  - Word address = cpu_addr >> L, zero-filled to addr_width.
  - Lane offset = cpu_addr[L-1:0] (no lane bits when wordsize=8).
  - Misaligned when the offset is not a multiple of access_bytes.
- Lane order: little-endian; byte offset 0 = bits [7:0].
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
  - IDLE + cpu_req + misaligned -> DONE with cpu_err=1. No RAM activity.
  - IDLE + cpu_req + load -> RD_ISSUE; ram_addr is loaded on this edge.
  - IDLE + cpu_req + full-width store -> WR; ram_addr and ram_wdata = cpu_wdata are loaded, ram_we=1.
  - IDLE + cpu_req + sub-word store -> RD_ISSUE. The request fields are latched internally; the CPU may change its inputs afterwards.
  - RD_ISSUE -> RD_WAIT.
  - RD_WAIT, load: cpu_rdata <= lane extracted from ram_rdata; -> DONE.
  - RD_WAIT, sub-word store: ram_wdata <= ram_rdata with the lane replaced by the low access_bytes*8 bits of the latched wdata; ram_we <= 1; -> WR.
  - WR: ram_we <= 0; -> DONE.
  - DONE: cpu_done=1 (plus cpu_err if set); -> IDLE.
- Latency, counted from the req edge to the cycle in which cpu_done is high:
  - misaligned: 1
  - full store: 2
  - load: 3
  - sub-word store: 4
- ram_we is high for exactly one cycle per store.
- cpu_req outside IDLE is ignored; requests are not queued. A request may be accepted in the cycle after DONE.
- cpu_rdata holds its value until the next load completes. Stores and errors leave it unchanged.
- cpu_err clears when the FSM leaves DONE.

Decomposition:
- Shared include (reflet.vh style `define header): size codes, FSM state encodings, and the function mapping size code to access_bytes.
- One sub-module, reflet_lane_merge (combinational):
  - inputs: word, lane data, offset, size
  - outputs: extracted lane (zero-extended) and the merged word.
  - Used in RD_WAIT for both loads and stores.

Test Plan:
- wordsize=32, RAM[0x1]=0xAABBCCDD; load size 11, addr 0x6 -> cpu_rdata=0x000000BB, cpu_done 3 cycles after req, cpu_err=0.
- wordsize=32, RAM[0x1]=0xAABBCCDD; store size 10, addr 0x4, wdata 0x1234 -> single ram_we pulse writing 0xAABB1234, cpu_done at cycle 4.
- wordsize=16, store size 01 (reduced to full), addr 0x2, wdata 0xBEEF -> ram_we at cycle 1 with ram_addr=0x1 and ram_wdata=0xBEEF, cpu_done at cycle 2, access_bytes=2.
- wordsize=32, load size 10, addr 0x3 -> cpu_done and cpu_err=1 at cycle 1; no ram_we; cpu_rdata unchanged.
- Sub-word store with reset=0 asserted in RD_WAIT -> ram_we never asserted, outputs 0, FSM in IDLE; a new request the cycle after reset is released completes normally.
- Back-to-back: req held high continuously -> second access accepted the cycle after cpu_done; requests during busy states are ignored.
